// File: rtl/grid_renderer.sv
// grid_renderer: ROWS x COLS cell-map pixel renderer with per-row colour, palette modes,
// a 2-stage pixel pipeline with delay-matched syncs, and a row-sweep clear.
module grid_renderer #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int ROW_W  = 3,
    parameter int CELL_W = 80,
    parameter int CELL_H = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    input  logic             inDisplayArea,
    input  logic [9:0]       CounterX,
    input  logic [9:0]       CounterY,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic [1:0]       wr_color,
    input  logic             clr,
    input  logic [1:0]       colorschm,
    output logic             busy,
    output logic             vga_h_sync,
    output logic             vga_v_sync,
    output logic [2:0]       vga_r,
    output logic [2:0]       vga_g,
    output logic [1:0]       vga_b
);
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t           state_q, state_d;
    logic [ROW_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic [COLS-1:0]  cell_q [ROWS];
    logic [COLS-1:0]  cell_d [ROWS];
    logic [1:0]       color_q [ROWS];
    logic [1:0]       color_d [ROWS];
    logic [3:0]       col_q, col_d, srow_q, srow_d;
    logic             in_grid_q, in_grid_d;
    logic             hs1_q, hs1_d, vs1_q, vs1_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [7:0]       rgb_q, rgb_d;
    logic [9:0]       col_full, srow_full;
    logic [3:0]       ridx, cidx;
    logic             lit;
    logic [1:0]       row_color, pal_idx;

    assign col_full  = CounterX / 10'(CELL_W);
    assign srow_full = CounterY / 10'(CELL_H);

    always_comb begin
        col_d     = col_full[3:0];
        srow_d    = srow_full[3:0];
        in_grid_d = inDisplayArea && (col_full < 10'(COLS)) && (srow_full < 10'(ROWS));
        hs1_d     = h_sync_in;
        vs1_d     = v_sync_in;
        hs2_d     = hs1_q;
        vs2_d     = vs1_q;
        ridx      = 4'(ROWS - 1) - srow_q;
        cidx      = 4'(COLS - 1) - col_q;
        lit       = 1'b0;
        row_color = 2'd0;
        for (int r = 0; r < ROWS; r++)
            if (ridx == 4'(r)) begin
                row_color = color_q[r];
                for (int c = 0; c < COLS; c++)
                    if (cidx == 4'(c)) lit = cell_q[r][c];
            end
        // non-zero scheme forces one palette entry; 00 uses the row's stored index
        pal_idx = (colorschm == 2'd0) ? row_color : colorschm;
        rgb_d   = !(lit && in_grid_q) ? 8'h00 :
                  (pal_idx == 2'd0)   ? 8'hFF :
                  (pal_idx == 2'd1)   ? 8'h1C :
                  (pal_idx == 2'd2)   ? 8'hE0 : 8'h03;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        cell_d  = cell_q;
        color_d = color_q;
        if (state_q == SWEEP)
            for (int r = 0; r < ROWS; r++)
                if (ptr_q == ROW_W'(r)) begin
                    cell_d[r]  = '0;
                    color_d[r] = 2'd0;
                end
        if (clr) begin
            state_d = SWEEP;
            ptr_d   = ROW_W'(ROWS - 1);
            busy_d  = 1'b1;
        end else if (state_q == SWEEP) begin
            ptr_d = ptr_q - 1'b1;
            if (ptr_q == '0) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end else if (wr_en) begin
            for (int r = 0; r < ROWS; r++)
                if (wr_row == ROW_W'(r)) begin
                    cell_d[r]  = wr_data;
                    color_d[r] = wr_color;
                end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            cell_q    <= '{default: '0};
            color_q   <= '{default: '0};
            col_q     <= '0;
            srow_q    <= '0;
            in_grid_q <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            rgb_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            cell_q    <= cell_d;
            color_q   <= color_d;
            col_q     <= col_d;
            srow_q    <= srow_d;
            in_grid_q <= in_grid_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            rgb_q     <= rgb_d;
        end
    end

    assign busy                  = busy_q;
    assign vga_h_sync            = hs2_q;
    assign vga_v_sync            = vs2_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: randomized and directed checks of grid_renderer against a
// behavioural pixel model built from cell/palette arithmetic.
module tb_grid_renderer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hs_in = 1'b0, vs_in = 1'b0, disp = 1'b0;
    logic [9:0]  cx = '0, cy = '0;
    logic        wr_en = 1'b0, clr = 1'b0;
    logic [2:0]  wr_row = '0;
    logic [7:0]  wr_data = '0;
    logic [1:0]  wr_color = '0, schm = '0;
    logic        busy, vhs, vvs;
    logic [2:0]  vr, vg;
    logic [1:0]  vb;
    logic        s_wr_en = 1'b0, s_clr = 1'b0;
    logic [2:0]  s_wr_row = '0;
    logic [15:0] s_wr_data = '0;
    logic [1:0]  s_wr_color = '0;
    logic        s_busy, s_hs, s_vs;
    logic [2:0]  s_r, s_g;
    logic [1:0]  s_b;

    int tests = 0, fails = 0;
    logic [7:0] m_cell [8];
    logic [1:0] m_colr [8];
    int px [301], py [301];
    logic pd [301], ph [301], pv [301];
    logic [1:0] ps [301];

    always #5 clk = ~clk;

    grid_renderer u_dut (
        .clk(clk), .reset(reset), .h_sync_in(hs_in), .v_sync_in(vs_in), .inDisplayArea(disp),
        .CounterX(cx), .CounterY(cy), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .wr_color(wr_color), .clr(clr), .colorschm(schm), .busy(busy),
        .vga_h_sync(vhs), .vga_v_sync(vvs), .vga_r(vr), .vga_g(vg), .vga_b(vb)
    );

    grid_renderer #(.ROWS(4), .COLS(16), .ROW_W(3), .CELL_W(40), .CELL_H(120)) u_small (
        .clk(clk), .reset(reset), .h_sync_in(hs_in), .v_sync_in(vs_in), .inDisplayArea(disp),
        .CounterX(cx), .CounterY(cy), .wr_en(s_wr_en), .wr_row(s_wr_row), .wr_data(s_wr_data),
        .wr_color(s_wr_color), .clr(s_clr), .colorschm(schm), .busy(s_busy),
        .vga_h_sync(s_hs), .vga_v_sync(s_vs), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
    );

    function automatic logic [7:0] pal(input logic [1:0] i);
        logic [7:0] white = {3'd7, 3'd7, 2'd3};
        logic [7:0] green = {3'd0, 3'd7, 2'd0};
        logic [7:0] red   = {3'd7, 3'd0, 2'd0};
        logic [7:0] blue  = {3'd0, 3'd0, 2'd3};
        case (i)
            2'd0: return white;
            2'd1: return green;
            2'd2: return red;
            default: return blue;
        endcase
    endfunction

    function automatic logic [7:0] exp_pix(input int x, input int y, input logic d, input logic [1:0] s);
        int col = x / 80;
        int srow = y / 60;
        int r;
        if (!d || col >= 8 || srow >= 8) return 8'h00;
        r = 7 - srow;
        if (!m_cell[r][7 - col]) return 8'h00;
        return pal(s == 2'd0 ? m_colr[r] : s);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int row, input logic [7:0] d, input logic [1:0] c);
        wr_en = 1'b1; wr_row = 3'(row); wr_data = d; wr_color = c;
        tick();
        wr_en = 1'b0;
        m_cell[row] = d;
        m_colr[row] = c;
    endtask

    task automatic fill(input logic [7:0] d);
        for (int r = 0; r < 8; r++) wr(r, d, 2'(r));
    endtask

    task automatic model_clear;
        for (int r = 0; r < 8; r++) begin
            m_cell[r] = '0;
            m_colr[r] = '0;
        end
    endtask

    task automatic read_pix(input int x, input int y, input logic d, output logic [7:0] m, output logic [7:0] s);
        cx = 10'(x); cy = 10'(y); disp = d;
        tick();
        tick();
        m = {vr, vg, vb};
        s = {s_r, s_g, s_b};
    endtask

    task automatic test_reset;
        logic [7:0] m, s;
        reset = 1'b0; hs_in = 1'b0; vs_in = 1'b0; disp = 1'b1;
        model_clear();
        tick(); tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if ({vhs, vvs} !== 2'b11) begin fails++; $display("FAIL reset_syncs: got %b want 11", {vhs, vvs}); end
        tests++; if ({vr, vg, vb} !== 8'h00) begin fails++; $display("FAIL reset_rgb: got %h want 00", {vr, vg, vb}); end
        reset = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
        read_pix(0, 479, 1'b1, m, s);
        tests++; if (m !== exp_pix(0, 479, 1'b1, schm)) begin fails++; $display("FAIL reset_cells: got %h want %h", m, exp_pix(0, 479, 1'b1, schm)); end
    endtask

    task automatic test_row_write;
        logic [7:0] m, s;
        int xs [3] = '{0, 80, 639};
        schm = 2'd0;
        wr(0, 8'b1000_0001, 2'd2);
        for (int i = 0; i < 3; i++) begin
            read_pix(xs[i], 479, 1'b1, m, s);
            tests++; if (m !== exp_pix(xs[i], 479, 1'b1, 2'd0)) begin fails++; $display("FAIL row_write x=%0d: got %h want %h", xs[i], m, exp_pix(xs[i], 479, 1'b1, 2'd0)); end
        end
    endtask

    task automatic test_scheme;
        logic [7:0] m, s;
        schm = 2'd3;
        wr(7, 8'hFF, 2'd0);
        read_pix(0, 0, 1'b1, m, s);
        tests++; if (m !== 8'h03) begin fails++; $display("FAIL scheme_blue: got %h want 03", m); end
        read_pix(0, 0, 1'b0, m, s);
        tests++; if (m !== 8'h00) begin fails++; $display("FAIL scheme_blank: got %h want 00", m); end
    endtask

    task automatic test_stream;
        logic [7:0] e;
        for (int r = 0; r < 8; r++) wr(r, 8'($urandom), 2'($urandom));
        for (int i = 0; i <= 300; i++) begin
            px[i] = $urandom_range(0, 799); py[i] = $urandom_range(0, 524);
            pd[i] = ($urandom_range(0, 3) != 0); ph[i] = 1'($urandom); pv[i] = 1'($urandom);
            ps[i] = 2'($urandom);
            cx = 10'(px[i]); cy = 10'(py[i]); disp = pd[i]; hs_in = ph[i]; vs_in = pv[i]; schm = ps[i];
            tick();
            if (i >= 1) begin
                e = exp_pix(px[i-1], py[i-1], pd[i-1], ps[i]);
                tests++;
                if ({vr, vg, vb, vhs, vvs} !== {e, ph[i-1], pv[i-1]}) begin
                    fails++;
                    $display("FAIL stream i=%0d (%0d,%0d): got rgb %h sync %b%b want rgb %h sync %b%b",
                             i, px[i-1], py[i-1], {vr, vg, vb}, vhs, vvs, e, ph[i-1], pv[i-1]);
                end
            end
        end
        hs_in = 1'b1; vs_in = 1'b1; disp = 1'b1;
    endtask

    task automatic test_clear;
        logic [7:0] m, s;
        logic [7:0] obs [9];
        logic [7:0] expb [7];
        int cnt;
        schm = 2'd0;
        fill(8'hFF);
        clr = 1'b1; tick(); clr = 1'b0;
        cnt = busy ? 1 : 0;
        for (int m2 = 0; m2 <= 8; m2++) begin
            cx = '0; cy = 10'((m2 % 8) * 60); disp = 1'b1;
            wr_en = (m2 == 2); wr_row = 3'd7; wr_data = 8'hFF; wr_color = 2'd1;
            tick();
            wr_en = 1'b0;
            if (busy) cnt++;
            tests++; if (busy !== (m2 <= 6)) begin fails++; $display("FAIL clear_busy m=%0d: got %b want %b", m2, busy, m2 <= 6); end
            obs[m2] = {vr, vg, vb};
        end
        tests++; if (cnt != 8) begin fails++; $display("FAIL clear_busy_len: got %0d want 8", cnt); end
        for (int m2 = 0; m2 < 8; m2++) begin
            tests++; if (obs[m2+1] !== 8'h00) begin fails++; $display("FAIL clear_order row=%0d: got %h want 00", 7 - m2, obs[m2+1]); end
        end
        model_clear();
        read_pix(0, 0, 1'b1, m, s);
        tests++; if (m !== exp_pix(0, 0, 1'b1, 2'd0)) begin fails++; $display("FAIL clear_midwrite: got %h want %h", m, exp_pix(0, 0, 1'b1, 2'd0)); end
        fill(8'hFF);
        for (int m2 = 0; m2 < 7; m2++) expb[m2] = exp_pix(0, (m2 + 1) * 60, 1'b1, 2'd0);
        clr = 1'b1; tick(); clr = 1'b0;
        for (int m2 = 0; m2 <= 8; m2++) begin
            cx = '0; cy = 10'(((m2 + 1) % 8) * 60);
            wr_en = (m2 >= 7); wr_row = (m2 == 7) ? 3'd5 : 3'd6; wr_data = 8'hFF; wr_color = 2'd2;
            tick();
            wr_en = 1'b0;
            obs[m2] = {vr, vg, vb};
        end
        for (int m2 = 0; m2 < 7; m2++) begin
            tests++; if (obs[m2+1] !== expb[m2]) begin fails++; $display("FAIL clear_pending row=%0d: got %h want %h", 6 - m2, obs[m2+1], expb[m2]); end
        end
        model_clear();
        m_cell[6] = 8'hFF; m_colr[6] = 2'd2;
        read_pix(0, 60, 1'b1, m, s);
        tests++; if (m !== exp_pix(0, 60, 1'b1, 2'd0)) begin fails++; $display("FAIL clear_first_write: got %h want %h", m, exp_pix(0, 60, 1'b1, 2'd0)); end
        read_pix(0, 120, 1'b1, m, s);
        tests++; if (m !== exp_pix(0, 120, 1'b1, 2'd0)) begin fails++; $display("FAIL clear_last_drop: got %h want %h", m, exp_pix(0, 120, 1'b1, 2'd0)); end
    endtask

    task automatic test_clr_wr;
        logic [7:0] m, s;
        int cnt, j;
        fill(8'hFF);
        clr = 1'b1; wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hAA; wr_color = 2'd1;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        cnt = busy ? 1 : 0;
        j = 1;
        while (busy && j < 40) begin
            clr = (j == 4);
            tick();
            clr = 1'b0;
            if (busy) cnt++;
            j++;
        end
        tests++; if (cnt != 12) begin fails++; $display("FAIL restart_busy_len: got %0d want 12", cnt); end
        model_clear();
        for (int c = 0; c < 8; c += 2) begin
            read_pix(c * 80, 240, 1'b1, m, s);
            tests++; if (m !== exp_pix(c * 80, 240, 1'b1, schm)) begin fails++; $display("FAIL clr_wr_row3 col=%0d: got %h want %h", c, m, exp_pix(c * 80, 240, 1'b1, schm)); end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] m, s;
        schm = 2'd0;
        fill(8'hFF);
        clr = 1'b1; tick(); clr = 1'b0;
        cx = '0; cy = 10'd479; disp = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        tick(); tick();
        tests++; if ({vr, vg, vb, vhs} !== {exp_pix(0, 479, 1'b1, 2'd0), 1'b0}) begin fails++; $display("FAIL pre_reset: got %h/%b want %h/0", {vr, vg, vb}, vhs, exp_pix(0, 479, 1'b1, 2'd0)); end
        #2 reset = 1'b0;
        #1;
        tests++; if ({busy, vhs, vvs, vr, vg, vb} !== {3'b011, 8'h00}) begin fails++; $display("FAIL async_reset: got busy %b sync %b%b rgb %h want busy 0 sync 11 rgb 00", busy, vhs, vvs, {vr, vg, vb}); end
        tick();
        reset = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
        model_clear();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                read_pix(c * 80, (7 - r) * 60, 1'b1, m, s);
                tests++; if (m !== exp_pix(c * 80, (7 - r) * 60, 1'b1, 2'd0)) begin fails++; $display("FAIL reset_array r=%0d c=%0d: got %h want 00", r, c, m); end
            end
    endtask

    task automatic test_param;
        logic [7:0] m, s;
        schm = 2'd2;
        s_wr_en = 1'b1; s_wr_row = 3'd3; s_wr_data = 16'h0001; s_wr_color = 2'd0;
        tick();
        s_wr_row = 3'd5; s_wr_data = 16'hFFFF;
        tick();
        s_wr_en = 1'b0;
        read_pix(600, 0, 1'b1, m, s);
        tests++; if (s !== 8'hE0) begin fails++; $display("FAIL param_col15: got %h want e0", s); end
        read_pix(560, 0, 1'b1, m, s);
        tests++; if (s !== 8'h00) begin fails++; $display("FAIL param_col14: got %h want 00", s); end
        read_pix(0, 240, 1'b1, m, s);
        tests++; if (s !== 8'h00) begin fails++; $display("FAIL param_row5_alias: got %h want 00", s); end
        read_pix(0, 360, 1'b1, m, s);
        tests++; if (s !== 8'h00) begin fails++; $display("FAIL param_row5_drop: got %h want 00", s); end
    endtask

    initial begin
        test_reset();
        test_row_write();
        test_scheme();
        test_stream();
        test_clear();
        test_clr_wr();
        test_reset_mid();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end
endmodule
